// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: shared widths and encoding constants for the write-back commit slice
package wb_commit_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;
    localparam logic [DATA_W-1:0] ZeroWord   = '0;
    localparam logic [ADDR_W-1:0] NOPRegAddr = '0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;
endpackage

// File: rtl/wb_commit_gpr_file.sv
// wb_commit_gpr_file: 32x32 GPR storage with one write port and two write-through read ports
module wb_commit_gpr_file
    import wb_commit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wd,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re1,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic              i_re2,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);
    logic [DATA_W-1:0] r_regs [REG_NUM];

    // register write; index 0 is never written so it always reads as zero
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= ZeroWord;
        end else if (i_we == WriteEnable && i_wd != NOPRegAddr) begin
            r_regs[i_wd] <= i_wdata;
        end
    end

    // read port 1: reset/disable/zero-index gate, then same-cycle bypass of the committing write
    always_comb begin
        o_rdata1 = (rst == RstEnable || i_re1 == ReadDisable || i_raddr1 == NOPRegAddr) ? ZeroWord :
                   (i_we == WriteEnable && i_wd == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    end

    // read port 2: identical priority to port 1, fully independent
    always_comb begin
        o_rdata2 = (rst == RstEnable || i_re2 != ReadEnable || i_raddr2 == NOPRegAddr) ? ZeroWord :
                   (i_we == WriteEnable && i_wd == i_raddr2) ? i_wdata : r_regs[i_raddr2];
    end
endmodule

// File: rtl/wb_commit.sv
// wb_commit: WB-stage commit of GPR, HI/LO and LLbit writes plus a commit counter
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o,
    output logic [CNT_W-1:0]  commit_cnt
);
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_llbit;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_commit;

    assign w_commit = (wb_wreg == WriteEnable && wb_wd != NOPRegAddr) ||
                      wb_whilo == WriteEnable || wb_LLbit_we != WriteDisable;

    wb_commit_gpr_file u_gpr (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_wreg),
        .i_wd     (wb_wd),
        .i_wdata  (wb_wdata),
        .i_re1    (re1),
        .i_raddr1 (raddr1),
        .o_rdata1 (rdata1),
        .i_re2    (re2),
        .i_raddr2 (raddr2),
        .o_rdata2 (rdata2)
    );

    // HI/LO pair is written as a unit; no bypass here, EX forwards HI/LO itself
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_hi <= ZeroWord;
            r_lo <= ZeroWord;
        end else if (wb_whilo == WriteEnable) begin
            r_hi <= wb_hi;
            r_lo <= wb_lo;
        end
    end

    // LLbit: an exception flush breaks any pending LL/SC pair and beats a same-cycle write
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) r_llbit <= 1'b0;
        else if (wb_LLbit_we == WriteEnable) r_llbit <= wb_LLbit_value;
    end

    // one count per committing cycle regardless of how many write kinds it carries; wraps silently
    always_ff @(posedge clk) begin
        if (rst == RstEnable) r_cnt <= '0;
        else if (w_commit) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign LLbit_o    = r_llbit;
    assign commit_cnt = r_cnt;
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: scenario tasks with a queue scoreboard for the write-back commit unit
module tb_wb_commit;
    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;
    logic [31:0] commit_cnt;
    logic [31:0] rdata1_n;
    logic [31:0] rdata2_n;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        ll_n;
    logic [3:0]  commit_cnt4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_ll;
    logic [31:0] m_cnt;

    wb_commit dut (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_LLbit_we(wb_LLbit_we),
        .wb_LLbit_value(wb_LLbit_value), .flush(flush), .re1(re1), .raddr1(raddr1),
        .rdata1(rdata1), .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .hi_o(hi_o),
        .lo_o(lo_o), .LLbit_o(LLbit_o), .commit_cnt(commit_cnt)
    );

    wb_commit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_LLbit_we(wb_LLbit_we),
        .wb_LLbit_value(wb_LLbit_value), .flush(flush), .re1(re1), .raddr1(raddr1),
        .rdata1(rdata1_n), .re2(re2), .raddr2(raddr2), .rdata2(rdata2_n), .hi_o(hi_n),
        .lo_o(lo_n), .LLbit_o(ll_n), .commit_cnt(commit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bubble();
        wb_wd = 0; wb_wreg = 0; wb_wdata = 0; wb_hi = 0; wb_lo = 0; wb_whilo = 0;
        wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_gpr[a];
    endfunction

    task automatic model_commit();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi = 0; m_lo = 0; m_ll = 0; m_cnt = 0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
            if (flush) m_ll = 1'b0;
            else if (wb_LLbit_we) m_ll = wb_LLbit_value;
            if ((wb_wreg && wb_wd != 5'd0) || wb_whilo || wb_LLbit_we) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        @(negedge clk);
        rst = 1; bubble(); re1 = 1; raddr1 = 5;
        model_commit();
        @(posedge clk); @(negedge clk);
        exp_q.push_back(exp_rd(re1, raddr1));
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL reset_rdata1_in_rst: got %h expected %h", rdata1, e); end
        @(negedge clk);
        rst = 0;
        exp_q.push_back(exp_rd(re1, raddr1));
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, e); end
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin errors++; $display("FAIL reset_hilo: got %h/%h expected %h/%h", hi_o, lo_o, m_hi, m_lo); end
        checks++;
        if (LLbit_o !== m_ll) begin errors++; $display("FAIL reset_llbit: got %b expected %b", LLbit_o, m_ll); end
        checks++;
        if (commit_cnt !== m_cnt) begin errors++; $display("FAIL reset_cnt: got %h expected %h", commit_cnt, m_cnt); end
    endtask

    task automatic test_gpr_bypass();
        logic [31:0] e;
        @(negedge clk);
        bubble(); wb_wd = 5; wb_wdata = 32'h1234_5678; wb_wreg = 1; re1 = 1; raddr1 = 5;
        exp_q.push_back(32'h1234_5678);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL gpr_bypass: got %h expected %h", rdata1, e); end
        model_commit();
        @(negedge clk);
        wb_wreg = 0; wb_wdata = 0;
        exp_q.push_back(32'h1234_5678);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL gpr_stored: got %h expected %h", rdata1, e); end
        checks++;
        if (commit_cnt !== 32'd1) begin errors++; $display("FAIL gpr_cnt: got %h expected %h", commit_cnt, 32'd1); end
    endtask

    task automatic test_zero_write();
        logic [31:0] e;
        @(negedge clk);
        bubble(); wb_wd = 0; wb_wdata = 32'hFFFF_FFFF; wb_wreg = 1; re2 = 1; raddr2 = 0;
        exp_q.push_back(32'd0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata2 !== e) begin errors++; $display("FAIL zero_same_cycle: got %h expected %h", rdata2, e); end
        model_commit();
        @(negedge clk);
        wb_wreg = 0;
        exp_q.push_back(32'd0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata2 !== e) begin errors++; $display("FAIL zero_next_cycle: got %h expected %h", rdata2, e); end
        checks++;
        if (commit_cnt !== m_cnt) begin errors++; $display("FAIL zero_cnt: got %h expected %h", commit_cnt, m_cnt); end
    endtask

    task automatic test_hilo();
        @(negedge clk);
        bubble(); wb_whilo = 1; wb_hi = 32'hAAAA_0001; wb_lo = 32'h5555_0002;
        #1 checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin errors++; $display("FAIL hilo_no_bypass: got %h/%h expected %h/%h", hi_o, lo_o, m_hi, m_lo); end
        model_commit();
        @(posedge clk); #1 checks++;
        if (hi_o !== 32'hAAAA_0001 || lo_o !== 32'h5555_0002) begin errors++; $display("FAIL hilo_write: got %h/%h expected aaaa0001/55550002", hi_o, lo_o); end
    endtask

    task automatic test_llbit();
        @(negedge clk);
        bubble(); wb_LLbit_we = 1; wb_LLbit_value = 1;
        model_commit();
        @(posedge clk); #1 checks++;
        if (LLbit_o !== 1'b1) begin errors++; $display("FAIL llbit_set: got %b expected 1", LLbit_o); end
        @(negedge clk);
        flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
        model_commit();
        @(posedge clk); #1 checks++;
        if (LLbit_o !== 1'b0) begin errors++; $display("FAIL llbit_flush: got %b expected 0", LLbit_o); end
        checks++;
        if (commit_cnt !== m_cnt) begin errors++; $display("FAIL llbit_cnt: got %h expected %h", commit_cnt, m_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            wb_wd = 5'($urandom_range(0, 31)); wb_wreg = 1'($urandom_range(0, 1));
            wb_wdata = $urandom; wb_hi = $urandom; wb_lo = $urandom;
            wb_whilo = 1'($urandom_range(0, 1)); wb_LLbit_we = 1'($urandom_range(0, 1));
            wb_LLbit_value = 1'($urandom_range(0, 1)); flush = ($urandom_range(0, 3) == 0);
            re1 = ($urandom_range(0, 5) != 0); re2 = ($urandom_range(0, 5) != 0);
            raddr1 = $urandom_range(0, 1) ? wb_wd : 5'($urandom_range(0, 31));
            raddr2 = $urandom_range(0, 2) == 0 ? raddr1 : 5'($urandom_range(0, 31));
            exp_q.push_back(exp_rd(re1, raddr1));
            exp_q.push_back(exp_rd(re2, raddr2));
            model_commit();
            #1 e1 = exp_q.pop_front(); e2 = exp_q.pop_front(); checks++;
            if (rdata1 !== e1 || rdata2 !== e2) begin errors++; $display("FAIL b2b_read[%0d]: got %h/%h expected %h/%h", n, rdata1, rdata2, e1, e2); end
            @(posedge clk); #1 checks++;
            if (hi_o !== m_hi || lo_o !== m_lo || LLbit_o !== m_ll || commit_cnt !== m_cnt) begin
                errors++;
                $display("FAIL b2b_state[%0d]: got %h/%h/%b/%h expected %h/%h/%b/%h", n, hi_o, lo_o, LLbit_o, commit_cnt, m_hi, m_lo, m_ll, m_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        @(negedge clk);
        bubble(); rst = 1;
        model_commit();
        @(negedge clk);
        rst = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            bubble(); wb_whilo = 1; wb_hi = n; wb_lo = ~n;
            model_commit();
            exp_q.push_back(m_cnt);
            @(posedge clk); #1 e = exp_q.pop_front(); checks++;
            if (commit_cnt4 !== e[3:0] || commit_cnt !== e) begin errors++; $display("FAIL wrap_cnt[%0d]: got %h/%h expected %h/%h", n, commit_cnt4, commit_cnt, e[3:0], e); end
        end
        checks++;
        if (commit_cnt4 !== 4'd0) begin errors++; $display("FAIL wrap_to_zero: got %h expected 0", commit_cnt4); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bubble(); rst = 1; wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hDEAD_BEEF; wb_whilo = 1; wb_hi = 32'h1;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        #1 checks++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin errors++; $display("FAIL rst_forced_read: got %h/%h expected 0/0", rdata1, rdata2); end
        model_commit();
        @(negedge clk);
        rst = 0; wb_wreg = 0; wb_whilo = 0;
        #1 checks++;
        if (rdata1 !== m_gpr[7]) begin errors++; $display("FAIL rst_gpr7: got %h expected %h", rdata1, m_gpr[7]); end
        checks++;
        if (commit_cnt !== 32'd0 || hi_o !== 32'd0) begin errors++; $display("FAIL rst_state: got %h/%h expected 0/0", commit_cnt, hi_o); end
    endtask

    initial begin
        rst = 1;
        bubble();
        test_reset();
        test_gpr_bypass();
        test_zero_write();
        test_hilo();
        test_llbit();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
